// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : FSM state encoding and byte-merge helper for registerfile_p.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } regfile_state_e;

  // One byte lane of a partial write: new data where enabled, old data otherwise.
  function automatic logic [7:0] merge_byte(
    input logic [7:0] stored,
    input logic [7:0] wdata,
    input logic       en
  );
    return en ? wdata : stored;
  endfunction

endpackage
`default_nettype wire

// File: rtl/registerfile_p.sv
`default_nettype none
// ============================================================================
// Module   : registerfile_p
// Brief    : 1W/2R byte-enabled register file with a self-timed clear sweep.
//            Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to reads.
// Revision : 1.0
// ============================================================================
module registerfile_p
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addre_wr,
  input  logic [DATA_W-1:0]   D,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addre_rdA,
  input  logic [ADDR_W-1:0]   addre_rdB,
  output logic [DATA_W-1:0]   QA,
  output logic [DATA_W-1:0]   QB,
  output logic                busy
);

  localparam int C_DEPTH = 2 ** ADDR_W;
  localparam int C_NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [C_DEPTH];
  regfile_state_e    r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [DATA_W-1:0] w_wr_merged;
  logic              w_busy;
  logic              w_byp_a;
  logic              w_byp_b;

  assign w_busy = (r_state == CLEAR);
  assign busy   = w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
          end
        end
        CLEAR: begin
          if (r_clr_ptr == {ADDR_W{1'b1}}) begin
            r_state <= IDLE;
          end
          r_clr_ptr <= r_clr_ptr + 1'b1;
        end
        default: begin
          r_state   <= CLEAR;
          r_clr_ptr <= '0;
        end
      endcase
    end
  end

  // The merged word feeds both the array write and the optional read bypass.
  for (genvar i = 0; i < C_NBYTES; i++) begin : g_byte
    assign w_wr_merged[8*i +: 8] = merge_byte(r_mem[addre_wr][8*i +: 8], D[8*i +: 8], be[i]);
  end

  // Array has no reset; contents are defined once a sweep completes.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (we && !rst) begin
      r_mem[addre_wr] <= w_wr_merged;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign w_byp_a = we && (addre_rdA == addre_wr);
  assign w_byp_b = we && (addre_rdB == addre_wr);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  always_comb begin
    QA = '0;
    QB = '0;
    if (!w_busy) begin
      QA = w_byp_a ? w_wr_merged : r_mem[addre_rdA];
      QB = w_byp_b ? w_wr_merged : r_mem[addre_rdB];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_registerfile_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_registerfile_p
// Brief    : Scoreboard bench for registerfile_p (DATA_W=16, ADDR_W=3).
// Revision : 1.0
// ============================================================================
module tb_registerfile_p;

  localparam int C_KIND_QA   = 0;
  localparam int C_KIND_QB   = 1;
  localparam int C_KIND_BUSY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  addre_wr = '0;
  logic [15:0] D = '0;
  logic [1:0]  be = '0;
  logic [2:0]  addre_rdA = '0;
  logic [2:0]  addre_rdB = '0;
  logic [15:0] QA;
  logic [15:0] QB;
  logic        busy;

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  registerfile_p #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .addre_wr(addre_wr), .D(D), .be(be),
    .addre_rdA(addre_rdA), .addre_rdB(addre_rdB), .QA(QA), .QB(QB), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input int kind, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Monitor: DUT outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [15:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        C_KIND_QA: act = QA;
        C_KIND_QB: act = QB;
        default:   act = {15'b0, busy};
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    // Reset sweep: one cycle of rst, then busy for 8 cycles.
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_val("rst_busy", C_KIND_BUSY, 16'd1);
      expect_val("rst_qa_zero", C_KIND_QA, 16'd0);
      step();
    end
    expect_val("rst_busy_done", C_KIND_BUSY, 16'd0);
    for (int a = 0; a < 8; a++) begin
      addre_rdA = 3'(a);
      addre_rdB = 3'(7 - a);
      expect_val("swept_qa", C_KIND_QA, 16'd0);
      expect_val("swept_qb", C_KIND_QB, 16'd0);
      step();
    end

    // Full-word writes and dual reads.
    we = 1'b1; be = 2'b11;
    addre_wr = 3'd1; D = 16'd10; step();
    addre_wr = 3'd3; D = 16'd8;  step();
    we = 1'b0;
    addre_rdA = 3'd3; addre_rdB = 3'd1;
    expect_val("rd_a3", C_KIND_QA, 16'd8);
    expect_val("rd_b1", C_KIND_QB, 16'd10);
    step();
    addre_rdA = 3'd1; addre_rdB = 3'd1;
    expect_val("same_addr_a", C_KIND_QA, 16'd10);
    expect_val("same_addr_b", C_KIND_QB, 16'd10);
    step();

    // Byte-enable merges.
    we = 1'b1; addre_wr = 3'd7; D = 16'h1234; be = 2'b11; step();
    D = 16'hABCD; be = 2'b01; step();
    we = 1'b0; addre_rdA = 3'd7;
    expect_val("be_low", C_KIND_QA, 16'h12CD);
    step();
    we = 1'b1; D = 16'h55AA; be = 2'b10; step();
    we = 1'b0;
    expect_val("be_high", C_KIND_QA, 16'h55CD);
    step();
    we = 1'b1; D = 16'hFFFF; be = 2'b00; step();
    we = 1'b0;
    expect_val("be_none", C_KIND_QA, 16'h55CD);
    step();

    // Same-cycle read of the address being written.
    we = 1'b1; addre_wr = 3'd5; D = 16'd20; be = 2'b11;
    addre_rdA = 3'd5; addre_rdB = 3'd4;
`ifdef REGFILE_BYPASS_EN
    expect_val("bypass_same_cycle", C_KIND_QA, 16'd20);
`else
    expect_val("no_bypass_same_cycle", C_KIND_QA, 16'd0);
`endif
    expect_val("bypass_other_port", C_KIND_QB, 16'd0);
    step();
    we = 1'b0;
    expect_val("write_next_cycle", C_KIND_QA, 16'd20);
    step();

    // Clear sweep: dropped write, clr re-assertion ignored.
    clr = 1'b1; step();
    clr = 1'b0;
    we = 1'b1; addre_wr = 3'd2; D = 16'h7777; be = 2'b11; addre_rdA = 3'd2;
    expect_val("clr_busy0", C_KIND_BUSY, 16'd1);
    expect_val("clr_qa_forced", C_KIND_QA, 16'd0);
    step();
    we = 1'b0;
    for (int i = 1; i < 8; i++) begin
      clr = (i == 3);
      expect_val("clr_busy", C_KIND_BUSY, 16'd1);
      step();
    end
    clr = 1'b0;
    expect_val("clr_done", C_KIND_BUSY, 16'd0);
    expect_val("clr_dropped_write", C_KIND_QA, 16'd0);
    addre_rdB = 3'd1;
    expect_val("clr_zeroed", C_KIND_QB, 16'd0);
    step();

    // Reset in the middle of a sweep restarts it.
    clr = 1'b1; step();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_val("pre_rst_busy", C_KIND_BUSY, 16'd1);
      step();
    end
    rst = 1'b1;
    expect_val("rst_mid_busy", C_KIND_BUSY, 16'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_val("restart_busy", C_KIND_BUSY, 16'd1);
      step();
    end
    expect_val("restart_done", C_KIND_BUSY, 16'd0);
    step();
    step();

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
